// File: rtl/imem_fetch_controller_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds the state encoding, datapath widths and the sequential PC step.
package imem_fetch_controller_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 64;
  localparam int CNT_W   = 4;

  localparam logic [PC_W-1:0] PC_INC = 64'd4;

endpackage

// File: rtl/imem_fetch_controller_addr_check.sv
// Combinational fetch address check: flags word-misaligned PCs and PCs
// at or beyond the end of the implemented instruction image.
module imem_fetch_controller_addr_check
  import imem_fetch_controller_pkg::*;
#(
  parameter logic [PC_W-1:0] MEM_BYTES = 64'h68
) (
  input  logic [PC_W-1:0] pc_i,
  output logic            fault_o
);

  assign fault_o = (pc_i[1:0] != 2'b00) || (pc_i >= MEM_BYTES);

endmodule

// File: rtl/imem_fetch_controller.sv
// Instruction fetch sequencer: holds Address for WAIT_CYCLES, captures Data,
// presents it to decode over valid/ready, and handles redirects and faults.
module imem_fetch_controller
  import imem_fetch_controller_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = 64'h0,
  parameter int unsigned     WAIT_CYCLES = 2,
  parameter logic [PC_W-1:0] MEM_BYTES   = 64'h68
) (
  input  logic               CLK,
  input  logic               Reset,
  output logic [PC_W-1:0]    Address,
  input  logic [INSTR_W-1:0] Data,
  output logic [INSTR_W-1:0] InstrOut,
  output logic [PC_W-1:0]    PCOut,
  output logic               InstrValid,
  input  logic               InstrReady,
  input  logic               RedirectValid,
  input  logic [PC_W-1:0]    RedirectPC,
  output logic               Fault,
  output logic [PC_W-1:0]    FaultPC,
  output logic [31:0]        FetchCount
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_out_q, pc_out_d;
  logic               valid_q, valid_d;
  logic               fault_q, fault_d;
  logic [PC_W-1:0]    fault_pc_q, fault_pc_d;
  logic [31:0]        count_q, count_d;
  logic               addr_fault;
  logic               handshake;

  imem_fetch_controller_addr_check #(
    .MEM_BYTES(MEM_BYTES)
  ) u_addr_check (
    .pc_i   (pc_q),
    .fault_o(addr_fault)
  );

  assign handshake = valid_q && InstrReady;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    count_d    = count_q;

    unique case (state_q)
      FETCH: begin
        if (RedirectValid) begin
          pc_d    = RedirectPC;
          cnt_d   = WAIT_INIT;
          valid_d = 1'b0;
        end else if (addr_fault) begin
          state_d    = FAULT;
          fault_d    = 1'b1;
          fault_pc_d = pc_q;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          instr_d  = Data;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          state_d  = VALID;
        end
      end

      VALID: begin
        // A handshake still counts when a redirect lands in the same cycle;
        // the redirect only decides where fetch goes next.
        if (handshake) begin
          count_d = count_q + 32'd1;
        end
        if (RedirectValid || handshake) begin
          pc_d    = RedirectValid ? RedirectPC : (pc_q + PC_INC);
          cnt_d   = WAIT_INIT;
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end

      FAULT: begin
        if (RedirectValid) begin
          pc_d    = RedirectPC;
          cnt_d   = WAIT_INIT;
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      cnt_q      <= WAIT_INIT;
      instr_q    <= '0;
      pc_out_q   <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  assign Address    = pc_q;
  assign InstrOut   = instr_q;
  assign PCOut      = pc_out_q;
  assign InstrValid = valid_q;
  assign Fault      = fault_q;
  assign FaultPC    = fault_pc_q;
  assign FetchCount = count_q;

endmodule

// File: tb/tb_imem_fetch_controller.sv
// Bench for imem_fetch_controller: directed scenarios followed by random
// ready/redirect/reset traffic, all checked against a cycle-level model.
module tb_imem_fetch_controller;

  localparam logic [63:0] RESET_PC    = 64'h0;
  localparam int          WAIT_CYCLES = 2;
  localparam logic [63:0] MEM_BYTES   = 64'h68;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [63:0] Address;
  logic [31:0] Data;
  logic [31:0] InstrOut;
  logic [63:0] PCOut;
  logic        InstrValid;
  logic        InstrReady;
  logic        RedirectValid;
  logic [63:0] RedirectPC;
  logic        Fault;
  logic [63:0] FaultPC;
  logic [31:0] FetchCount;

  logic [31:0] memImage [0:31];

  int compareCount  = 0;
  int mismatchCount = 0;

  // Reference model: the PC being fetched, how many cycles it has been on
  // the bus, and what decode should currently see.
  logic [63:0] modelPc, modelPcOut, modelFaultPc;
  logic [31:0] modelInstr, modelCount;
  logic        modelValid, modelFault, modelHalted;
  int          modelAge;

  imem_fetch_controller #(
    .RESET_PC   (RESET_PC),
    .WAIT_CYCLES(WAIT_CYCLES),
    .MEM_BYTES  (MEM_BYTES)
  ) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .Address      (Address),
    .Data         (Data),
    .InstrOut     (InstrOut),
    .PCOut        (PCOut),
    .InstrValid   (InstrValid),
    .InstrReady   (InstrReady),
    .RedirectValid(RedirectValid),
    .RedirectPC   (RedirectPC),
    .Fault        (Fault),
    .FaultPC      (FaultPC),
    .FetchCount   (FetchCount)
  );

  always #5 CLK = ~CLK;

  assign Data = (Address < MEM_BYTES) ? memImage[Address[6:2]] : 32'hDEAD_BEEF;

  function automatic logic [31:0] memWord(input logic [63:0] a);
    return memImage[a[6:2]];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelStep(input logic rst, input logic rdy, input logic rv,
                           input logic [63:0] rpc);
    logic hs;
    if (rst) begin
      modelPc = RESET_PC; modelAge = 0; modelValid = 1'b0; modelHalted = 1'b0;
      modelInstr = '0; modelPcOut = '0; modelFault = 1'b0; modelFaultPc = '0;
      modelCount = '0;
      return;
    end
    hs = modelValid && rdy;
    if (hs) modelCount = modelCount + 32'd1;
    if (rv) begin
      modelPc = rpc; modelAge = 0; modelValid = 1'b0; modelHalted = 1'b0;
    end else if (hs) begin
      modelPc = modelPc + 64'd4; modelAge = 0; modelValid = 1'b0;
    end else if (modelValid || modelHalted) begin
      // decode is stalling, or fetch is parked on a fault
    end else if (modelPc[1:0] != 2'b00 || modelPc >= MEM_BYTES) begin
      modelHalted = 1'b1; modelFault = 1'b1; modelFaultPc = modelPc;
    end else begin
      modelAge++;
      if (modelAge == WAIT_CYCLES + 1) begin
        modelValid = 1'b1; modelInstr = memWord(modelPc); modelPcOut = modelPc;
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("Address", Address, modelPc);
    checkOutput("InstrValid", InstrValid, modelValid);
    checkOutput("InstrOut", InstrOut, modelInstr);
    checkOutput("PCOut", PCOut, modelPcOut);
    checkOutput("Fault", Fault, modelFault);
    checkOutput("FaultPC", FaultPC, modelFaultPc);
    checkOutput("FetchCount", FetchCount, modelCount);
  endtask

  task automatic applyStimulus(input logic rst, input logic rdy, input logic rv,
                               input logic [63:0] rpc);
    Reset = rst; InstrReady = rdy; RedirectValid = rv; RedirectPC = rpc;
    @(posedge CLK);
    modelStep(rst, rdy, rv, rpc);
    #1;
    checkAll();
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] heldCount;
    logic [63:0] rpc;
    logic        rst, rdy, rv;

    for (int i = 0; i < 32; i++) memImage[i] = $urandom;
    memImage[0]  = 32'hF840_03E9;
    memImage[1]  = 32'hF840_83EA;
    memImage[11] = 32'hF802_03ED;

    // Reset and the first two sequential fetches
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("resetAddress", Address, 64'h0);
    checkOutput("resetValid", InstrValid, 1'b0);
    checkOutput("resetCount", FetchCount, 32'd0);
    repeat (WAIT_CYCLES) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
      checkOutput("holdAddr0", Address, 64'h0);
      checkOutput("waitValid0", InstrValid, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
    checkOutput("firstValid", InstrValid, 1'b1);
    checkOutput("firstInstr", InstrOut, 32'hF840_03E9);
    checkOutput("firstPc", PCOut, 64'h0);
    repeat (WAIT_CYCLES + 2) applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
    checkOutput("secondInstr", InstrOut, 32'hF840_83EA);
    checkOutput("secondPc", PCOut, 64'h4);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
    checkOutput("twoHandshakes", FetchCount, 32'd2);

    // Backpressure at PC 0x8
    repeat (WAIT_CYCLES + 1) applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    repeat (5) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
      checkOutput("stallValid", InstrValid, 1'b1);
      checkOutput("stallInstr", InstrOut, memImage[2]);
      checkOutput("stallPc", PCOut, 64'h8);
      checkOutput("stallAddr", Address, 64'h8);
      checkOutput("stallCount", FetchCount, 32'd2);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
    checkOutput("releaseCount", FetchCount, 32'd3);
    checkOutput("releaseAddr", Address, 64'hC);

    // Redirect mid-wait away from 0x1C
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h1C);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h2C);
    repeat (WAIT_CYCLES) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
      checkOutput("noStaleValid", InstrValid, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("redirInstr", InstrOut, 32'hF802_03ED);
    checkOutput("redirPc", PCOut, 64'h2C);

    // Handshake and redirect in the same cycle at 0x28
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h28);
    repeat (WAIT_CYCLES + 1) applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    heldCount = FetchCount;
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h1C);
    checkOutput("hsRedirCount", FetchCount, modelCount);
    checkOutput("hsRedirCountInc", {32'h0, modelCount}, {32'h0, heldCount + 32'd1});
    repeat (WAIT_CYCLES + 1) applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("hsRedirPc", PCOut, 64'h1C);

    // Misaligned redirect, then recovery with Fault still latched
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h22);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("misFault", Fault, 1'b1);
    checkOutput("misFaultPc", FaultPC, 64'h22);
    repeat (3) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
      checkOutput("misNoValid", InstrValid, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h0);
    repeat (WAIT_CYCLES + 1) applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("resumeValid", InstrValid, 1'b1);
    checkOutput("resumeFault", Fault, 1'b1);

    // Sequential run off the end of the image, then reset from FAULT
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    for (int i = 0; i < 200 && !modelFault; i++) applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
    checkOutput("rangeFault", Fault, 1'b1);
    checkOutput("rangeFaultPc", FaultPC, 64'h68);
    checkOutput("rangeCount", FetchCount, 32'd26);
    applyStimulus(1'b1, 1'b1, 1'b1, 64'h40);
    checkOutput("rstFault", Fault, 1'b0);
    checkOutput("rstFaultPc", FaultPC, 64'h0);
    checkOutput("rstAddr", Address, RESET_PC);
    checkOutput("rstInstr", InstrOut, 32'h0);
    checkOutput("rstPcOut", PCOut, 64'h0);
    checkOutput("rstCount", FetchCount, 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      rv  = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0, 1:    rpc = {56'h0, 3'($urandom_range(0, 7)) ^ 3'h0, 5'h0} |
                       {57'h0, 5'($urandom_range(0, 25)), 2'b00};
        2:       rpc = {57'h0, 5'($urandom_range(0, 25)), 2'($urandom_range(1, 3))};
        default: rpc = {$urandom, $urandom} | 64'h100;
      endcase
      if (rpc >= MEM_BYTES && rpc < 64'h100) rpc = {57'h0, 5'($urandom_range(0, 25)), 2'b00};
      applyStimulus(rst, rdy, rv, rpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
